// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory, and registers the fetch->decode fields.
// Define IFETCH_PERF_CNT_EN to build the delivered-word and bubble counters; otherwise they read zero.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  JumpType,
    input  logic        CondSrc,
    input  logic        BranchCond,
    input  logic [31:0] RegOut1,
    input  logic        FPCond,
    input  logic [31:0] DecPCPlusFour,
    input  logic [15:0] Immediate,
    input  logic [25:0] DecOffset26,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    output logic [5:0]  NextOpCode,
    output logic [4:0]  NextRs1,
    output logic [4:0]  NextRs2,
    output logic [4:0]  NextRd,
    output logic [15:0] NextImmd,
    output logic [5:0]  NextFunct,
    output logic [31:0] NextPCPlusFour,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
);
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic {FETCH = 1'b0, BUF = 1'b1} fetch_state_t;

    fetch_state_t      state_p0, state_d;
    logic [DATA_W-1:0] pc_p0, pc_d;
    logic [DATA_W-1:0] hold_addr_p0, hold_addr_d;
    logic              squash_p0, squash_d;
    logic [DATA_W-1:0] skid_p0, skid_d;
    logic [DATA_W-1:0] ir_p1, ir_d;
    logic [DATA_W-1:0] npc4_p1, npc4_d;
    logic              deliver;

    logic              cond_true;
    logic              taken;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] pc_plus4;

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext26(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

    // Redirect resolution from decode-stage control
    always_comb begin
        cond_true = CondSrc ? FPCond : (RegOut1 == '0);
        if (JumpType == 2'b01) begin
            taken = (cond_true == BranchCond);
        end else begin
            taken = JumpType[1];
        end
        case (JumpType)
            2'b01:   target = DecPCPlusFour + $unsigned(sext16(Immediate));
            2'b10:   target = DecPCPlusFour + $unsigned(sext26(DecOffset26));
            default: target = RegOut1;
        endcase
    end

    assign pc_plus4 = pc_p0 + 32'd4;

    always_comb begin
        state_d     = state_p0;
        pc_d        = pc_p0;
        hold_addr_d = hold_addr_p0;
        squash_d    = squash_p0;
        skid_d      = skid_p0;
        ir_d        = ir_p1;
        npc4_d      = npc4_p1;
        deliver     = 1'b0;
        if (stall) begin
            // Output register frozen; a response arriving now is parked in the skid register.
            if (state_p0 == FETCH && IMemValid) begin
                if (squash_p0) begin
                    squash_d = 1'b0;
                end else begin
                    skid_d  = IMemData;
                    state_d = BUF;
                end
            end
        end else if (taken) begin
            pc_d    = target & ALIGN_MASK;
            ir_d    = NOP_WORD;
            state_d = FETCH;
            if (state_p0 == FETCH) begin
                if (IMemValid) begin
                    squash_d = 1'b0;
                end else if (!squash_p0) begin
                    // Memory still owes a word for the old PC: keep asking for it, then drop it.
                    squash_d    = 1'b1;
                    hold_addr_d = pc_p0;
                end
            end
        end else if (state_p0 == BUF) begin
            ir_d    = skid_p0;
            deliver = 1'b1;
            state_d = FETCH;
        end else if (IMemValid && !squash_p0) begin
            ir_d    = IMemData;
            deliver = 1'b1;
        end else begin
            ir_d = NOP_WORD;
            if (IMemValid) begin
                squash_d = 1'b0;
            end
        end
        if (deliver) begin
            npc4_d = pc_plus4;
            pc_d   = pc_plus4;
        end
    end

    // Stage boundary: PC/FSM state (p0) and fetch->decode register (p1)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0  <= FETCH;
            pc_p0     <= RESET_PC & ALIGN_MASK;
            squash_p0 <= 1'b0;
            ir_p1     <= NOP_WORD;
            npc4_p1   <= '0;
        end else begin
            state_p0  <= state_d;
            pc_p0     <= pc_d;
            squash_p0 <= squash_d;
            ir_p1     <= ir_d;
            npc4_p1   <= npc4_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_p0      <= skid_d;
        hold_addr_p0 <= hold_addr_d;
    end

    assign IMemReq  = reset && (state_p0 == FETCH);
    assign IMemAddr = squash_p0 ? hold_addr_p0 : pc_p0;

    // Word bit 0 is the MSB, so IR[0:5] is ir_p1[31:26]
    assign NextOpCode     = ir_p1[31:26];
    assign NextRs1        = ir_p1[25:21];
    assign NextRs2        = ir_p1[20:16];
    assign NextRd         = ir_p1[15:11];
    assign NextImmd       = ir_p1[15:0];
    assign NextFunct      = ir_p1[5:0];
    assign NextPCPlusFour = npc4_p1;

`ifdef IFETCH_PERF_CNT_EN
    logic [DATA_W-1:0] fetch_cnt_p1;
    logic [DATA_W-1:0] bubble_cnt_p1;

    // Every unstalled edge either delivers a word or inserts a NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_p1  <= '0;
            bubble_cnt_p1 <= '0;
        end else if (!stall) begin
            if (deliver) begin
                fetch_cnt_p1 <= fetch_cnt_p1 + 32'd1;
            end else begin
                bubble_cnt_p1 <= bubble_cnt_p1 + 32'd1;
            end
        end
    end

    assign FetchCount  = fetch_cnt_p1;
    assign BubbleCount = bubble_cnt_p1;
`else
    assign FetchCount  = '0;
    assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: latency-configurable instruction memory, reference fetch model, directed and random phases.
module tb_ifetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  JumpType = 2'b00;
    logic        CondSrc = 1'b0;
    logic        BranchCond = 1'b0;
    logic [31:0] RegOut1 = '0;
    logic        FPCond = 1'b0;
    logic [31:0] DecPCPlusFour = '0;
    logic [15:0] Immediate = '0;
    logic [25:0] DecOffset26 = '0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemData;
    logic [5:0]  NextOpCode;
    logic [4:0]  NextRs1;
    logic [4:0]  NextRs2;
    logic [4:0]  NextRd;
    logic [15:0] NextImmd;
    logic [5:0]  NextFunct;
    logic [31:0] NextPCPlusFour;
    logic [31:0] FetchCount;
    logic [31:0] BubbleCount;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ifetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .JumpType(JumpType), .CondSrc(CondSrc),
        .BranchCond(BranchCond), .RegOut1(RegOut1), .FPCond(FPCond), .DecPCPlusFour(DecPCPlusFour),
        .Immediate(Immediate), .DecOffset26(DecOffset26), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemValid(IMemValid), .IMemData(IMemData), .NextOpCode(NextOpCode), .NextRs1(NextRs1),
        .NextRs2(NextRs2), .NextRd(NextRd), .NextImmd(NextImmd), .NextFunct(NextFunct),
        .NextPCPlusFour(NextPCPlusFour), .FetchCount(FetchCount), .BubbleCount(BubbleCount)
    );

    // Instruction memory: word content is a fixed function of the address, never equal to NOP.
    int lat_cfg = 0;
    bit rand_lat = 1'b0;
    int req_lat = 0;
    int wait_cnt = 0;
    bit force_miss = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0) return 32'h20A3_0010;
        w = (a ^ 32'h3C6E_F372) * 32'h9E37_79B1;
        return w | 32'h0000_0001;
    endfunction

    assign IMemValid = IMemReq && !force_miss && (wait_cnt >= (rand_lat ? req_lat : lat_cfg));
    assign IMemData  = IMemValid ? mem_word(IMemAddr) : 32'hBAD0_BAD0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 0;
        end else if (IMemValid) begin
            wait_cnt <= 0;
            req_lat  <= int'($urandom_range(0, 3));
        end else if (IMemReq && wait_cnt < 15) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Reference model: what the fetch stage must present, in terms of PC and pending-word bookkeeping.
    logic [31:0] m_pc = '0, m_ir = '0, m_npc4 = '0, m_hold = '0;
    logic [31:0] m_fetch = '0, m_bubble = '0;
    bit          m_buffered = 1'b0, m_drop = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        cond, tk, got;
        logic [31:0] tgt;
        if (!reset) begin
            m_pc = '0; m_ir = '0; m_npc4 = '0; m_buffered = 1'b0; m_drop = 1'b0;
            m_fetch = '0; m_bubble = '0;
            return;
        end
        cond = CondSrc ? FPCond : (RegOut1 == 32'd0);
        tk   = (JumpType == 2'b01) ? (cond == BranchCond) : (JumpType >= 2'b10);
        case (JumpType)
            2'b01:   tgt = DecPCPlusFour + {{16{Immediate[15]}}, Immediate};
            2'b10:   tgt = DecPCPlusFour + {{6{DecOffset26[25]}}, DecOffset26};
            default: tgt = RegOut1;
        endcase
        got = IMemValid && !m_buffered;
        if (stall) begin
            if (got) begin
                if (m_drop) m_drop = 1'b0;
                else m_buffered = 1'b1;
            end
        end else if (tk) begin
            if (got) m_drop = 1'b0;
            else if (!m_buffered && !m_drop) begin
                m_drop = 1'b1;
                m_hold = m_pc;
            end
            m_buffered = 1'b0;
            m_pc       = tgt & 32'hFFFF_FFFC;
            m_ir       = '0;
            m_bubble   = m_bubble + 1;
        end else if (m_buffered || (got && !m_drop)) begin
            m_ir       = mem_word(m_pc);
            m_npc4     = m_pc + 4;
            m_pc       = m_pc + 4;
            m_buffered = 1'b0;
            m_fetch    = m_fetch + 1;
        end else begin
            if (got) m_drop = 1'b0;
            m_ir     = '0;
            m_bubble = m_bubble + 1;
        end
    endtask

    task automatic model_compare();
        if (!reset) begin
            chk("req_in_reset", 32'(IMemReq), 32'd0);
            return;
        end
        chk("req", 32'(IMemReq), 32'(!m_buffered));
        if (!m_buffered) chk("addr", IMemAddr, m_drop ? m_hold : m_pc);
        chk("opcode", 32'(NextOpCode), 32'(m_ir[31:26]));
        chk("rs1", 32'(NextRs1), 32'(m_ir[25:21]));
        chk("rs2", 32'(NextRs2), 32'(m_ir[20:16]));
        chk("rd", 32'(NextRd), 32'(m_ir[15:11]));
        chk("immd", 32'(NextImmd), 32'(m_ir[15:0]));
        chk("funct", 32'(NextFunct), 32'(m_ir[5:0]));
        chk("npc4", NextPCPlusFour, m_npc4);
`ifdef IFETCH_PERF_CNT_EN
        chk("fetch_cnt", FetchCount, m_fetch);
        chk("bubble_cnt", BubbleCount, m_bubble);
`else
        chk("fetch_cnt", FetchCount, 32'd0);
        chk("bubble_cnt", BubbleCount, 32'd0);
`endif
    endtask

    // Inputs are driven right after a negedge; the model samples them just before the posedge.
    task automatic tick();
        #3;
        model_step();
        @(negedge clk);
        model_compare();
    endtask

    initial begin
        int sel;
        repeat (3) tick();
        chk("rst_npc4", NextPCPlusFour, 32'd0);
        chk("rst_opcode", 32'(NextOpCode), 32'd0);
        reset = 1'b1;

        // Zero-wait memory: consecutive words, field split of 32'h20A3_0010
        tick();
        chk("w0_opcode", 32'(NextOpCode), 32'h08);
        chk("w0_rs1", 32'(NextRs1), 32'd5);
        chk("w0_rs2", 32'(NextRs2), 32'd3);
        chk("w0_rd", 32'(NextRd), 32'd0);
        chk("w0_immd", 32'(NextImmd), 32'h0010);
        chk("w0_funct", 32'(NextFunct), 32'h10);
        chk("w0_npc4", NextPCPlusFour, 32'd4);
        tick();
        chk("w1_npc4", NextPCPlusFour, 32'd8);
        tick();
        chk("w2_npc4", NextPCPlusFour, 32'd12);

        // Latency-3 response arriving under a 5-cycle stall
        lat_cfg = 3;
        tick(); tick();
        stall = 1'b1;
        tick(); tick(); tick();
        chk("buf_req", 32'(IMemReq), 32'd0);
        chk("buf_npc4", NextPCPlusFour, 32'd12);
        tick(); tick();
        stall = 1'b0;
        tick();
        chk("rel_npc4", NextPCPlusFour, 32'd16);
        chk("rel_addr", IMemAddr, 32'd16);

        // Taken BEQZ with negative offset
        lat_cfg = 0; JumpType = 2'b01; CondSrc = 1'b0; BranchCond = 1'b1; RegOut1 = '0;
        DecPCPlusFour = 32'h100; Immediate = 16'hFFF0;
        tick();
        chk("br_opcode", 32'(NextOpCode), 32'd0);
        chk("br_immd", 32'(NextImmd), 32'd0);
        chk("br_addr", IMemAddr, 32'hF0);

        // JR while a latency-2 request is outstanding
        JumpType = 2'b00; lat_cfg = 2;
        tick();
        JumpType = 2'b11; RegOut1 = 32'h2000;
        tick();
        chk("jr_hold_addr", IMemAddr, 32'hF0);
        JumpType = 2'b00; RegOut1 = '0;
        tick();
        chk("jr_addr", IMemAddr, 32'h2000);
        chk("jr_discard_immd", 32'(NextImmd), 32'd0);

        // PC wrap from the top of the address space
        lat_cfg = 0; JumpType = 2'b11; RegOut1 = 32'hFFFF_FFFC;
        tick();
        chk("wrap_top_addr", IMemAddr, 32'hFFFF_FFFC);
        JumpType = 2'b00; RegOut1 = '0;
        tick();
        chk("wrap_addr", IMemAddr, 32'd0);
        chk("wrap_npc4", NextPCPlusFour, 32'd0);

        // Reset in the middle of a pending request drops IMemReq at once
        lat_cfg = 3;
        tick();
        reset = 1'b0;
        #1;
        chk("async_req_drop", 32'(IMemReq), 32'd0);
        tick();
        lat_cfg = 0; reset = 1'b1;

        // 10 delivered words and 3 miss cycles from reset
        for (int i = 0; i < 13; i++) begin
            force_miss = (i == 4 || i == 8 || i == 9);
            tick();
        end
        force_miss = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetch", FetchCount, 32'd10);
        chk("perf_bubble", BubbleCount, 32'd3);
`else
        chk("perf_fetch_off", FetchCount, 32'd0);
        chk("perf_bubble_off", BubbleCount, 32'd0);
`endif

        // Randomized traffic: stalls, branches, jumps, variable latency, one mid-run reset
        rand_lat = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            stall = ($urandom_range(0, 4) == 0);
            sel   = int'($urandom_range(0, 15));
            JumpType = (sel < 10) ? 2'b00 : (sel < 13) ? 2'b01 : (sel < 14) ? 2'b10 : 2'b11;
            CondSrc    = 1'($urandom);
            BranchCond = 1'($urandom);
            FPCond     = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       RegOut1 = '0;
                1:       RegOut1 = 32'hFFFF_FFF4;
                default: RegOut1 = $urandom;
            endcase
            DecPCPlusFour = $urandom;
            Immediate     = 16'($urandom);
            DecOffset26   = 26'($urandom);
            if (c == 2000) reset = 1'b0;
            if (c == 2002) reset = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
